// File: rtl/frame_mode_sched_pkg.sv
//==============================================================================
// Module   : frame_mode_sched_pkg
// Brief    : Shared types for the frame-synchronous mode scheduler: mode
//            encodings, FSM states, status-LED bit positions and LED packing.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package frame_mode_sched_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t DIRECT    = 2'b00;
   localparam mode_t INV       = 2'b01;
   localparam mode_t BLK_DARK  = 2'b10;
   localparam mode_t BLK_LIGHT = 2'b11;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      ACTIVE  = 2'd1,
      NOSIG   = 2'd2
   } state_t;

   localparam int LED_BLK  = 0;
   localparam int LED_RSVD = 1;
   localparam int LED_STAT = 2;
   localparam int LED_INV  = 3;

   // Status LEDs: invert bit, block bit, status lamp; reserved bit is always off
   function automatic logic [3:0] led_pack(input mode_t mode, input logic stat);
      logic [3:0] led;
      led           = 4'b0000;
      led[LED_INV]  = mode[0];
      led[LED_BLK]  = mode[1];
      led[LED_STAT] = stat;
      led[LED_RSVD] = 1'b0;
      return led;
   endfunction

endpackage

`default_nettype wire

// File: rtl/frame_luma_stat.sv
//==============================================================================
// Module   : frame_luma_stat
// Brief    : Per-frame gray-level accumulator; flags a frame as bright when its
//            mean gray exceeds BRIGHT_TH. Only built with FRAME_MODE_AUTO_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifdef FRAME_MODE_AUTO_EN
module frame_luma_stat #(
   parameter int BRIGHT_TH = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       de,
   input  logic [2:0] gray,
   input  logic       frame_end,
   output logic       bright
);

   logic [23:0] sum;
   logic [21:0] count;

   // mean > TH  <=>  sum > TH*count, avoiding a divider
   assign bright = ({2'b00, sum} > (26'(BRIGHT_TH) * {4'b0000, count}));

   // Accumulate active pixels; restart at every frame boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum   <= '0;
         count <= '0;
      end else if (frame_end) begin
         sum   <= '0;
         count <= '0;
      end else if (de) begin
         sum   <= sum + {21'd0, gray};
         count <= count + 22'd1;
      end
   end

endmodule
`endif

`default_nettype wire

// File: rtl/frame_mode_sched.sv
//==============================================================================
// Module   : frame_mode_sched
// Brief    : Collects inversion-mode requests and commits them only on vsync
//            rising edges; a watchdog drops into NOSIG (immediate commits) when
//            vsync disappears. Optional auto-invert under FRAME_MODE_AUTO_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module frame_mode_sched
   import frame_mode_sched_pkg::*;
#(
   parameter int    TIMEOUT     = 2_500_000,
   parameter mode_t RESET_MODE  = BLK_DARK,
   parameter int    AUTO_FRAMES = 8,
   parameter int    BRIGHT_TH   = 5
) (
   input  logic       vin_clk_i,
   input  logic       rst_n,
   input  logic       vs_i,
   input  logic       de_i,
   input  logic [2:0] gray_i,
   input  logic       req_blk_i,
   input  logic       req_inv_i,
   input  logic       hold_direct_i,
   input  logic       auto_en_i,
   output logic [1:0] mode_o,
   output logic       commit_o,
   output logic       nosig_o,
   output logic [3:0] led_o
);

   localparam logic [31:0] WD_MAX = 32'(TIMEOUT - 1);

   state_t      state;
   logic        vs_q;
   logic        vs_rise;
   logic [1:0]  req;
   logic [1:0]  pending;
   mode_t       base;
   logic        hold_q;
   logic [31:0] wd_cnt;
   logic        auto_flip;
   logic        auto_next;
   mode_t       base_next;
   mode_t       mode_next;

   assign vs_rise = vs_i & ~vs_q;
   assign req     = {req_blk_i, req_inv_i};

`ifdef FRAME_MODE_AUTO_EN
   logic       bright;
   logic       auto_state;
   logic [3:0] streak;
   logic [4:0] streak_inc;

   frame_luma_stat #(
      .BRIGHT_TH (BRIGHT_TH)
   ) u_luma_stat (
      .clk       (vin_clk_i),
      .rst_n     (rst_n),
      .de        (de_i),
      .gray      (gray_i),
      .frame_end (vs_rise),
      .bright    (bright)
   );

   assign streak_inc = {1'b0, streak} + 5'd1;
   assign auto_flip  = vs_rise & auto_en_i & (bright != auto_state) &
                       (streak_inc == 5'(AUTO_FRAMES));
   assign auto_next  = auto_state ^ auto_flip;

   // Count consecutive frames disagreeing with the auto state; toggle on a full streak
   always_ff @(posedge vin_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         streak     <= '0;
         auto_state <= 1'b0;
      end else if (vs_rise) begin
         if (!auto_en_i || (bright == auto_state)) begin
            streak <= '0;
         end else if (auto_flip) begin
            streak     <= '0;
            auto_state <= ~auto_state;
         end else begin
            streak <= streak_inc[3:0];
         end
      end
   end
`else
   logic unused_auto;
   assign unused_auto = (^{auto_en_i, de_i, gray_i}) ^ (AUTO_FRAMES > 0) ^ (BRIGHT_TH > 0);
   assign auto_flip   = 1'b0;
   assign auto_next   = 1'b0;
`endif

   // Candidate base folds in same-cycle requests; hold overrides to DIRECT
   always_comb begin
      base_next = base ^ pending ^ req ^ {1'b0, auto_flip};
      mode_next = hold_direct_i ? DIRECT : base_next;
   end

   // Frame-synchronous commit FSM with vsync watchdog; all outputs registered
   always_ff @(posedge vin_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_VS;
         vs_q     <= 1'b0;
         pending  <= 2'b00;
         base     <= RESET_MODE;
         hold_q   <= 1'b0;
         wd_cnt   <= '0;
         mode_o   <= RESET_MODE;
         commit_o <= 1'b0;
         nosig_o  <= 1'b0;
         led_o    <= led_pack(RESET_MODE, 1'b0);
      end else begin
         vs_q     <= vs_i;
         commit_o <= 1'b0;
         if (vs_rise) begin
            state    <= ACTIVE;
            base     <= base_next;
            pending  <= 2'b00;
            hold_q   <= hold_direct_i;
            wd_cnt   <= '0;
            mode_o   <= mode_next;
            commit_o <= 1'b1;
            nosig_o  <= 1'b0;
            led_o    <= led_pack(mode_next, auto_next);
         end else begin
            case (state)
               NOSIG: begin
                  // No frame timing to wait for: apply every change at once
                  base     <= base_next;
                  pending  <= 2'b00;
                  hold_q   <= hold_direct_i;
                  mode_o   <= mode_next;
                  commit_o <= (base_next != base) || (hold_direct_i != hold_q);
                  led_o    <= led_pack(mode_next, 1'b1);
               end
               default: begin
                  pending <= pending ^ req;
                  if (wd_cnt == WD_MAX) begin
                     if (state == ACTIVE) begin
                        state   <= NOSIG;
                        nosig_o <= 1'b1;
                        led_o   <= led_pack(mode_o, 1'b1);
                     end
                  end else begin
                     wd_cnt <= wd_cnt + 32'd1;
                  end
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/frame_mode_sched.md
Name: frame_mode_sched

Overview:
- Frame-synchronous scheduler for the output-inversion datapath.
- Collects mode-change requests from the user buttons and the hold-for-direct input, and commits them only at vertical-sync boundaries so the inversion mode never changes mid-frame (no tearing).
- Runs a watchdog that commits requests when the input signal is lost.
- Sits between the button debouncer and the pixel-inversion select; drives the mode select and the status LEDs.

Parameters:
- TIMEOUT, 2_500_000, vin_clk_i cycles without a vs_i rising edge before entering NOSIG.
- RESET_MODE, 2'd2, mode loaded on reset (BLK_DARK).
- AUTO_FRAMES, 8, consecutive qualifying frames needed for an auto toggle (optional feature only).
- BRIGHT_TH, 5, mean-gray threshold on the 0..7 scale (optional feature only).

Ports:
- vin_clk_i  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- vs_i  in  1  vertical sync, active-high, registered input stream
- de_i  in  1  data enable
- gray_i  in  3  per-pixel gray level, aligned with de_i
- req_blk_i  in  1  one-cycle pulse: toggle block mode
- req_inv_i  in  1  one-cycle pulse: toggle invert
- hold_direct_i  in  1  level: force DIRECT while high
- auto_en_i  in  1  level: enable auto-invert (ignored without the macro)
- mode_o  out  2  committed mode
- commit_o  out  1  one-cycle pulse when mode_o is updated
- nosig_o  out  1  high while in NOSIG
- led_o  out  4  status LEDs

Behaviour:
- Mode encoding: DIRECT=00, INV=01, BLK_DARK=10, BLK_LIGHT=11.
  - req_blk flips bit1; req_inv flips bit0.
- Reset values: mode_o=RESET_MODE, commit_o=0, nosig_o=0, led_o=0001, pending mask=00, hold latch=0. FSM enters WAIT_VS.
- Pending mask (2 bits) accumulates requests by XOR:
  - pending ^= {req_blk_i, req_inv_i} each cycle.
  - Two presses of the same button within one frame cancel out.
  - Simultaneous blk and inv presses flip both bits.
- Frame edge: vs_rise = vs_i & ~vs_q, where vs_q is vs_i delayed one cycle.
- Commit on vs_rise (registered, visible the cycle after the edge is sampled):
  - base = base ^ pending, with pending |-> 00 on the same edge. A request arriving on the commit cycle itself is folded into the commit.
  - mode_o = hold_q ? DIRECT : base, where hold_q is hold_direct_i sampled at the commit.
  - commit_o=1 for exactly one cycle.
  - hold_direct_i changes therefore take effect only at a frame boundary. Releasing hold restores the latest base.
- FSM states:
  - WAIT_VS (after reset): vs_rise -> ACTIVE plus a commit.
  - ACTIVE: vs_rise -> ACTIVE plus a commit; watchdog count reaches TIMEOUT-1 -> NOSIG.
  - NOSIG: nosig_o=1. Requests and hold commit immediately every cycle (commit_o pulses on each change). vs_rise -> ACTIVE plus a normal commit.
- Watchdog counter:
  - 32-bit; clears on vs_rise; saturates at TIMEOUT-1.
  - Counts in WAIT_VS and ACTIVE; frozen in NOSIG.
- led_o:
  - Bit3 = mode_o[0], bit0 = mode_o[1], bit1 = 0.
  - Bit2 = nosig_o, or the auto state when the macro is enabled and the block is not in NOSIG.
- Asynchronous reset mid-frame: everything returns to reset values, pending requests are discarded, WAIT_VS.

Optional Feature:
Macro FRAME_MODE_AUTO_EN.
- Enabled:
  - Per frame, accumulate sum (24-bit) of gray_i and count (22-bit) of cycles with de_i high.
  - On vs_rise, the frame is bright if sum > BRIGHT_TH*count (unsigned, 26-bit compare), then sum and count clear.
  - A 4-bit streak counter increments on frames that disagree with the current auto state and clears on frames that agree.
  - When the streak reaches AUTO_FRAMES while auto_en_i=1: auto state toggles, bit0 of base flips at that same commit, and the streak clears.
  - auto_en_i=0: streak is held at 0.
  - led_o[2] = auto state when not in NOSIG.
- Disabled: no accumulators; auto_en_i is unused; led_o[2] = nosig_o.

Decomposition:
- Shared package holds:
  - the mode localparams DIRECT, INV, BLK_DARK, BLK_LIGHT (2-bit type);
  - the FSM state encoding WAIT_VS, ACTIVE, NOSIG;
  - the LED bit positions.
- One natural sub-module, frame_luma_stat: the sum/count accumulator and bright-frame compare. It is instantiated only under FRAME_MODE_AUTO_EN.

Test Plan:
- Reset, then vs_rise with no requests: mode_o=10, commit_o one pulse, led_o=0001.
- req_blk at line 5, req_inv at line 9, vs_rise: mode_o stays 10 until the edge, then becomes 01, led_o=1000.
- req_inv pulsed twice within one frame, then vs_rise: mode_o unchanged, commit_o still pulses.
- hold_direct_i high mid-frame: mode_o=00 only after the next vs_rise. Release plus vs_rise restores 10.
- Hold vs_i low for TIMEOUT cycles: nosig_o=1, led_o[2]=1. req_blk then commits within 1 cycle. A later vs_rise clears nosig_o.
- With FRAME_MODE_AUTO_EN, auto_en_i=1, all gray_i=7, AUTO_FRAMES=8: bit0 of mode_o flips on the 8th vs_rise, not the 7th.
